s2p_stream: RTL

S2P_STREAM -- requirements
Module: s2p_stream

---
 rtl/s2p_stream_if.sv | 23 ++
 rtl/s2p_stream.sv | 129 ++++++++++++
 2 files changed

// File: rtl/s2p_stream_if.sv
// Signal bundle for s2p_stream: serial beat input side and output word FIFO side.
// The producer/consumer (master) drives beats and dout_ready; the converter (slave) drives the rest.
interface s2p_stream_if #(
  parameter int WIDTH = 10,
  parameter int LANES = 1,
  parameter int DEPTH = 2
) ();
  logic                       en;
  logic                       sync;
  logic [LANES-1:0]           din;
  logic                       msb_first;
  logic [WIDTH-1:0]           dout;
  logic                       dout_valid;
  logic                       dout_ready;
  logic [$clog2(DEPTH+1)-1:0] level;
  logic                       sync_err;
  logic                       overflow;

  modport master (output en, sync, din, msb_first, dout_ready,
                  input  dout, dout_valid, level, sync_err, overflow);
  modport slave  (input  en, sync, din, msb_first, dout_ready,
                  output dout, dout_valid, level, sync_err, overflow);
endinterface

// File: rtl/s2p_stream.sv
// Serial-to-parallel word assembler with sync-based framing and a small output FIFO.
// Words are captured LANES bits per beat, in LSB- or MSB-first order latched at beat 0.
module s2p_stream #(
  parameter int WIDTH = 10,
  parameter int LANES = 1,
  parameter int DEPTH = 2
) (
  input logic         clk,
  input logic         rst,
  s2p_stream_if.slave bus
);
  localparam int BEATS = WIDTH / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int SW    = $clog2(WIDTH) + 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             msb_q, msb_d;
  logic             sync_err_q, sync_err_d;
  logic             overflow_q, overflow_d;

  logic             capture;
  logic             complete;
  logic             msb_eff;
  logic             push;
  logic [BW-1:0]    idx;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] base_word;
  logic [WIDTH-1:0] grp_mask;
  logic [WIDTH-1:0] cap_word;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             full;
  logic             pop;
  logic             push_ok;

  // Capture state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      bcnt_q     <= '0;
      word_q     <= '0;
      msb_q      <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
      msb_q      <= msb_d;
      sync_err_q <= sync_err_d;
    end
  end

  // Next-state: any captured sync beat restarts the word at beat 0
  always_comb begin
    capture   = bus.en && ((state_q == RECV) || bus.sync);
    idx       = bus.sync ? '0 : bcnt_q;
    msb_eff   = (idx == '0) ? bus.msb_first : msb_q;
    shamt     = msb_eff ? SW'((BEATS - 1 - int'(idx)) * LANES) : SW'(int'(idx) * LANES);
    grp_mask  = WIDTH'({LANES{1'b1}}) << shamt;
    base_word = (idx == '0) ? '0 : word_q;
    cap_word  = (base_word & ~grp_mask) | (WIDTH'(bus.din) << shamt);
    complete  = capture && (idx == LAST);

    state_d = state_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    msb_d   = msb_q;
    if (capture) begin
      state_d = RECV;
      msb_d   = msb_eff;
      bcnt_d  = complete ? '0 : idx + 1'b1;
      word_d  = complete ? '0 : cap_word;
    end
  end

  // Capture outputs: misalignment pulse and word push request
  always_comb begin
    sync_err_d = capture && (state_q == RECV) && bus.sync && (bcnt_q != '0);
    push       = complete;
  end

  // FIFO control; a push into a full FIFO succeeds only if the head leaves the same cycle
  always_comb begin
    full       = (count_q == LW'(DEPTH));
    pop        = (count_q != '0) && bus.dout_ready;
    push_ok    = push && (!full || pop);
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + LW'(push_ok) - LW'(pop);
    overflow_d = overflow_q || (push && !push_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_ptr_q] <= cap_word;
    end
  end

  assign bus.dout       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.dout_valid = (count_q != '0);
  assign bus.level      = count_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.overflow   = overflow_q;

endmodule
